// File: rtl/rd_acc_burst.sv
// Burst register-read accessor: one REGIF master read per word with address
// auto-increment, per-word timeout, and a 4-phase {code,data} response per word.
module rd_acc_burst #(
  parameter int          DATA_W      = 32,
  parameter int          LEN_W       = 4,
  parameter int          TIMEOUT_CYC = 1024,
  parameter logic [31:0] ACK_CODE    = 32'h1,
  parameter logic [31:0] NACK_CODE   = 32'h2,
  parameter logic [31:0] TMO_CODE    = 32'h3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          acc_addr,
  input  logic [LEN_W-1:0]     acc_len,
  input  logic                 acc_en,
  output logic                 acc_en_ack,
  output logic                 IP2Bus_MstRd_Req,
  output logic [31:0]          IP2Bus_Mst_Addr,
  input  logic                 Bus2IP_Mst_CmdAck,
  input  logic                 Bus2IP_Mst_Cmplt,
  input  logic                 Bus2IP_Mst_Error,
  input  logic [DATA_W-1:0]    Bus2IP_MstRd_d,
  input  logic                 Bus2IP_MstRd_src_rdy_n,
  output logic                 snd_resp,
  input  logic                 snd_resp_ack,
  output logic [31+DATA_W:0]   resp,
  input  logic                 my_regif,
  output logic                 drv_regif,
  output logic                 busy
);

  localparam int               TMR_W     = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [31:0]      ADDR_STEP = 32'(DATA_W / 8);

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_REQ, S_WAIT, S_RESP, S_RACK, S_RREL
  } state_t;

  state_t             state;
  logic [1:0]         acc_en_sync;
  logic [1:0]         ack_sync;
  logic               acc_en_s;
  logic               ack_s;
  logic               armed;
  logic [31:0]        cur_addr;
  logic [LEN_W-1:0]   remaining;
  logic [TMR_W-1:0]   timer;
  logic               err_flag;
  logic               tmo_flag;
  logic [DATA_W-1:0]  data_reg;

  assign acc_en_s = acc_en_sync[1];
  assign ack_s    = ack_sync[1];

  // The request synchroniser resets high so a host level still asserted across
  // reset is not mistaken for a fresh low-to-high request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_en_sync <= 2'b11;
      ack_sync    <= 2'b00;
    end else begin
      acc_en_sync <= {acc_en_sync[0], acc_en};
      ack_sync    <= {ack_sync[0], snd_resp_ack};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      armed            <= 1'b0;
      cur_addr         <= '0;
      remaining        <= '0;
      timer            <= '0;
      err_flag         <= 1'b0;
      tmo_flag         <= 1'b0;
      data_reg         <= '0;
      acc_en_ack       <= 1'b0;
      IP2Bus_MstRd_Req <= 1'b0;
      IP2Bus_Mst_Addr  <= '0;
      snd_resp         <= 1'b0;
      resp             <= '0;
      drv_regif        <= 1'b0;
      busy             <= 1'b0;
    end else begin
      acc_en_ack <= 1'b0;
      if (!acc_en_s) armed <= 1'b1;

      case (state)
        S_IDLE: begin
          if (acc_en_s && armed) begin
            armed      <= 1'b0;
            acc_en_ack <= 1'b1;
            cur_addr   <= acc_addr;
            remaining  <= (acc_len == '0) ? LEN_W'(1) : acc_len;
            err_flag   <= 1'b0;
            tmo_flag   <= 1'b0;
            busy       <= 1'b1;
            state      <= S_GRANT;
          end
        end

        S_GRANT: begin
          if (my_regif) begin
            drv_regif <= 1'b1;
            state     <= S_REQ;
          end
        end

        S_REQ: begin
          IP2Bus_MstRd_Req <= 1'b1;
          IP2Bus_Mst_Addr  <= cur_addr;
          timer            <= '0;
          err_flag         <= 1'b0;
          tmo_flag         <= 1'b0;
          state            <= S_WAIT;
        end

        S_WAIT: begin
          timer <= timer + TMR_W'(1);
          if (Bus2IP_Mst_CmdAck) IP2Bus_MstRd_Req <= 1'b0;
          if (Bus2IP_Mst_Cmplt && Bus2IP_Mst_Error) err_flag <= 1'b1;
          // Data arriving in the timeout cycle still counts as a good read.
          if (!Bus2IP_MstRd_src_rdy_n) begin
            data_reg         <= Bus2IP_MstRd_d;
            IP2Bus_MstRd_Req <= 1'b0;
            state            <= S_RESP;
          end else if (timer == TMR_LAST) begin
            data_reg         <= '0;
            IP2Bus_MstRd_Req <= 1'b0;
            tmo_flag         <= 1'b1;
            state            <= S_RESP;
          end
        end

        S_RESP: begin
          resp     <= {tmo_flag ? TMO_CODE : (err_flag ? NACK_CODE : ACK_CODE), data_reg};
          snd_resp <= 1'b1;
          state    <= S_RACK;
        end

        S_RACK: begin
          if (ack_s) begin
            snd_resp <= 1'b0;
            state    <= S_RREL;
          end
        end

        S_RREL: begin
          if (!ack_s) begin
            if (err_flag || tmo_flag || remaining == LEN_W'(1)) begin
              drv_regif <= 1'b0;
              busy      <= 1'b0;
              state     <= S_IDLE;
            end else begin
              remaining <= remaining - LEN_W'(1);
              cur_addr  <= cur_addr + ADDR_STEP;
              err_flag  <= 1'b0;
              state     <= S_REQ;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rd_acc_burst.sv
// Randomised burst-read bench: a queue-based model predicts read addresses and
// responses; a REGIF slave process and a response monitor check the DUT.
module tb_rd_acc_burst;
  localparam int          DATA_W = 32;
  localparam int          LEN_W  = 4;
  localparam int          TMO    = 16;
  localparam logic [31:0] ACK_C  = 32'h1;
  localparam logic [31:0] NACK_C = 32'h2;
  localparam logic [31:0] TMO_C  = 32'h3;

  logic              clk, rst_n;
  logic [31:0]       acc_addr;
  logic [LEN_W-1:0]  acc_len;
  logic              acc_en, acc_en_ack;
  logic              IP2Bus_MstRd_Req;
  logic [31:0]       IP2Bus_Mst_Addr;
  logic              Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error;
  logic [DATA_W-1:0] Bus2IP_MstRd_d;
  logic              Bus2IP_MstRd_src_rdy_n;
  logic              snd_resp, snd_resp_ack;
  logic [31+DATA_W:0] resp;
  logic              my_regif, drv_regif, busy;

  rd_acc_burst #(.DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .acc_addr(acc_addr), .acc_len(acc_len), .acc_en(acc_en), .acc_en_ack(acc_en_ack),
    .IP2Bus_MstRd_Req(IP2Bus_MstRd_Req), .IP2Bus_Mst_Addr(IP2Bus_Mst_Addr),
    .Bus2IP_Mst_CmdAck(Bus2IP_Mst_CmdAck), .Bus2IP_Mst_Cmplt(Bus2IP_Mst_Cmplt),
    .Bus2IP_Mst_Error(Bus2IP_Mst_Error), .Bus2IP_MstRd_d(Bus2IP_MstRd_d),
    .Bus2IP_MstRd_src_rdy_n(Bus2IP_MstRd_src_rdy_n),
    .snd_resp(snd_resp), .snd_resp_ack(snd_resp_ack), .resp(resp),
    .my_regif(my_regif), .drv_regif(drv_regif), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 good word, 1 bus error, 2 no data (timeout)
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  kind;
    logic [3:0]  dly;
  } plan_t;

  plan_t       plan_q[$];
  logic [63:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int resp_cnt = 0;
  int ack_limit = 32'h3fffffff;

  task automatic chk(input bit ok, input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // REGIF slave: serves each read request from the plan queue
  int    sl_st = 0;
  int    sl_dly = 0;
  int    tcnt = 0;
  plan_t sl_cur;
  logic  req_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      sl_st = 0;
      Bus2IP_Mst_CmdAck = 1'b0;
      Bus2IP_Mst_Cmplt = 1'b0;
      Bus2IP_Mst_Error = 1'b0;
      Bus2IP_MstRd_src_rdy_n = 1'b1;
    end else begin
      case (sl_st)
        0: if (IP2Bus_MstRd_Req && !req_prev) begin
          if (plan_q.size() == 0) begin
            chk(1'b0, "unexpected_read", 64'(IP2Bus_Mst_Addr), 64'h0);
          end else begin
            sl_cur = plan_q.pop_front();
            chk(IP2Bus_Mst_Addr == sl_cur.addr, "read_addr", 64'(IP2Bus_Mst_Addr), 64'(sl_cur.addr));
            chk(drv_regif, "drv_during_read", 64'(drv_regif), 64'h1);
            if (sl_cur.kind == 2'd2) begin
              tcnt = 0;
              sl_st = 3;
            end else begin
              Bus2IP_Mst_CmdAck = 1'b1;
              sl_dly = int'(sl_cur.dly);
              sl_st = 1;
            end
          end
        end
        1: begin
          Bus2IP_Mst_CmdAck = 1'b0;
          if (sl_dly == 0) begin
            Bus2IP_MstRd_src_rdy_n = 1'b0;
            Bus2IP_MstRd_d = sl_cur.data;
            Bus2IP_Mst_Cmplt = 1'b1;
            Bus2IP_Mst_Error = (sl_cur.kind == 2'd1);
            sl_st = 2;
          end else begin
            sl_dly--;
          end
        end
        2: begin
          Bus2IP_MstRd_src_rdy_n = 1'b1;
          Bus2IP_Mst_Cmplt = 1'b0;
          Bus2IP_Mst_Error = 1'b0;
          Bus2IP_MstRd_d = $urandom;
          sl_st = 0;
        end
        3: begin
          tcnt++;
          if (!IP2Bus_MstRd_Req) begin
            chk(tcnt == TMO, "timeout_req_drop", 64'(tcnt), 64'(TMO));
            sl_st = 0;
          end else if (tcnt > TMO + 4) begin
            chk(1'b0, "timeout_req_drop", 64'(tcnt), 64'(TMO));
            sl_st = 0;
          end
        end
        default: sl_st = 0;
      endcase
    end
    req_prev = IP2Bus_MstRd_Req;
  end

  // Response monitor: compares each response, then runs the 4-phase ack
  int          mo_st = 0;
  int          mo_dly = 0;
  logic [63:0] held;
  logic [63:0] mo_exp;
  always @(negedge clk) begin
    if (!rst_n) begin
      mo_st = 0;
      snd_resp_ack = 1'b0;
    end else begin
      case (mo_st)
        0: if (snd_resp) begin
          chk(drv_regif, "drv_during_resp", 64'(drv_regif), 64'h1);
          if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_resp", resp, 64'h0);
          end else begin
            mo_exp = exp_q.pop_front();
            chk(resp == mo_exp, "resp", resp, mo_exp);
          end
          resp_cnt++;
          $display("resp %0d code %h data %h", resp_cnt, resp[63:32], resp[31:0]);
          held = resp;
          mo_dly = $urandom_range(0, 4);
          mo_st = (resp_cnt > ack_limit) ? 5 : 1;
        end
        1: if (mo_dly == 0) begin
          snd_resp_ack = 1'b1;
          mo_st = 2;
        end else begin
          mo_dly--;
        end
        2: if (!snd_resp) begin
          chk(resp == held, "resp_hold", resp, held);
          mo_dly = $urandom_range(0, 4);
          mo_st = 3;
        end
        3: if (mo_dly == 0) begin
          snd_resp_ack = 1'b0;
          mo_st = 0;
        end else begin
          mo_dly--;
        end
        default: ;
      endcase
    end
  end

  task automatic start_burst(input logic [31:0] addr, input int len, input int gdel,
                             input int fail_at, input int fail_kind,
                             input bit use_d0, input logic [31:0] d0);
    int    n;
    int    cnt;
    bit    bad;
    plan_t p;
    n = (len == 0) ? 1 : len;
    for (int i = 0; i < n; i++) begin
      p.addr = addr + 32'(4 * i);
      p.data = (i == 0 && use_d0) ? d0 : $urandom;
      p.kind = (i == fail_at) ? 2'(fail_kind) : 2'd0;
      p.dly  = use_d0 ? 4'd3 : 4'($urandom_range(0, 5));
      plan_q.push_back(p);
      exp_q.push_back({(p.kind == 2'd2) ? TMO_C : ((p.kind == 2'd1) ? NACK_C : ACK_C),
                       (p.kind == 2'd2) ? 32'h0 : p.data});
      if (p.kind != 2'd0) break;
    end
    $display("burst addr %h len %0d grant_delay %0d fail_at %0d kind %0d", addr, len, gdel, fail_at, fail_kind);
    @(negedge clk);
    acc_addr = addr;
    acc_len = LEN_W'(len);
    acc_en = 1'b1;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!acc_en_ack && cnt < 10);
    chk(cnt == 3 && acc_en_ack, "accept_latency", 64'(cnt), 64'd3);
    acc_en = 1'b0;
    acc_addr = $urandom;
    acc_len = LEN_W'($urandom);
    @(negedge clk);
    chk(!acc_en_ack && busy, "ack_pulse_busy", 64'({acc_en_ack, busy}), 64'h1);
    bad = 1'b0;
    repeat (gdel) begin
      @(negedge clk);
      if (IP2Bus_MstRd_Req || drv_regif) bad = 1'b1;
    end
    if (gdel > 0) chk(!bad, "no_req_before_grant", 64'(bad), 64'h0);
    my_regif = 1'b1;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!IP2Bus_MstRd_Req && cnt < 10);
    chk(cnt == 2 && IP2Bus_MstRd_Req, "grant_to_req", 64'(cnt), 64'd2);
  endtask

  task automatic finish_burst();
    int cnt;
    cnt = 0;
    while (busy && cnt < 3000) begin @(negedge clk); cnt++; end
    chk(!busy, "burst_done", 64'(busy), 64'h0);
    chk(!drv_regif && !IP2Bus_MstRd_Req && !snd_resp && !snd_resp_ack, "idle_after_release",
        64'({drv_regif, IP2Bus_MstRd_Req, snd_resp, snd_resp_ack}), 64'h0);
    chk(exp_q.size() == 0 && plan_q.size() == 0, "words_outstanding",
        64'(exp_q.size() + plan_q.size()), 64'h0);
    exp_q.delete();
    plan_q.delete();
    my_regif = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int cnt;
    int base;
    int len;
    int fa;
    bit bad;
    rst_n = 1'b0;
    acc_addr = '0; acc_len = '0; acc_en = 1'b0; my_regif = 1'b0;
    Bus2IP_MstRd_d = '0;
    repeat (3) @(negedge clk);
    chk({acc_en_ack, IP2Bus_MstRd_Req, IP2Bus_Mst_Addr, snd_resp, resp, drv_regif, busy} == '0,
        "reset_outputs", 64'(busy), 64'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single word, fixed data
    start_burst(32'h100, 1, 0, -1, 0, 1'b1, 32'hCAFEF00D);
    finish_burst();
    // Address wrap at 2**32
    start_burst(32'hFFFFFFF8, 4, 1, -1, 0, 1'b0, 32'h0);
    finish_burst();
    // Bus error on second word aborts the burst
    start_burst(32'h2000, 3, 0, 1, 1, 1'b0, 32'h0);
    finish_burst();
    // Timeout on first word aborts the burst
    start_burst(32'h3000, 3, 2, 0, 2, 1'b0, 32'h0);
    finish_burst();
    // Grant held off
    start_burst(32'h4000, 2, 50, -1, 0, 1'b0, 32'h0);
    finish_burst();
    // Zero length means one word
    start_burst(32'h5000, 0, 0, -1, 0, 1'b0, 32'h0);
    finish_burst();

    // Reset during the second response of a four-word burst
    base = resp_cnt;
    ack_limit = base + 1;
    start_burst(32'h6000, 4, 0, -1, 0, 1'b0, 32'h0);
    cnt = 0;
    while (!(resp_cnt == base + 2 && snd_resp) && cnt < 2000) begin @(negedge clk); cnt++; end
    chk(resp_cnt == base + 2 && snd_resp, "second_resp_held", 64'(resp_cnt - base), 64'd2);
    acc_en = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk({acc_en_ack, IP2Bus_MstRd_Req, IP2Bus_Mst_Addr, snd_resp, resp, drv_regif, busy} == '0,
           "async_reset_outputs", 64'({snd_resp, drv_regif, busy}), 64'h0);
    exp_q.delete();
    plan_q.delete();
    my_regif = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ack_limit = 32'h3fffffff;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (acc_en_ack || busy) bad = 1'b1;
    end
    chk(!bad, "no_request_without_toggle", 64'(bad), 64'h0);
    acc_en = 1'b0;
    repeat (4) @(negedge clk);
    start_burst(32'h7000, 2, 0, -1, 0, 1'b0, 32'h0);
    finish_burst();

    // Randomised bursts
    for (int t = 0; t < 20; t++) begin
      len = $urandom_range(0, 15);
      fa = ($urandom_range(0, 2) == 0) ? $urandom_range(0, (len == 0) ? 0 : len - 1) : -1;
      start_burst($urandom & 32'hFFFFFFFC, len, $urandom_range(0, 5), fa,
                  $urandom_range(1, 2), 1'b0, 32'h0);
      finish_burst();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
